// File: rtl/fpu_dot_pkg.sv
// rtl/fpu_dot_pkg.sv - shared FSM state type and FP32 constants for the dot-product sequencer
package fpu_dot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_ADD_ISSUE,
        S_ADD_WAIT,
        S_FIN
    } seq_state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fpu_dot_sequencer_if.sv
// rtl/fpu_dot_sequencer_if.sv - operand push, control/status and engine handshake bundle
interface fpu_dot_sequencer_if #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
);
    logic [31:0]              op_a;
    logic [31:0]              op_b;
    logic                     op_valid;
    logic                     op_ready;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [LEN_W-1:0]         len;
    logic                     start;
    logic                     abort;
    logic                     busy;
    logic                     done;
    logic [31:0]              result;
    logic                     eng_reset;

    logic [31:0]              mul_a;
    logic [31:0]              mul_b;
    logic                     mul_a_stb;
    logic                     mul_b_stb;
    logic                     mul_a_ack;
    logic                     mul_b_ack;
    logic [31:0]              mul_z;
    logic                     mul_z_stb;
    logic                     mul_z_ack;

    logic [31:0]              add_a;
    logic [31:0]              add_b;
    logic                     add_a_stb;
    logic                     add_b_stb;
    logic                     add_a_ack;
    logic                     add_b_ack;
    logic [31:0]              add_z;
    logic                     add_z_stb;
    logic                     add_z_ack;

    // master is the sequencer; slave is the host plus the two FP engines
    modport master (
        input  op_a, op_b, op_valid, len, start, abort,
        output op_ready, fifo_count, busy, done, result, eng_reset,
        output mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack,
        input  mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        output add_a, add_b, add_a_stb, add_b_stb, add_z_ack,
        input  add_a_ack, add_b_ack, add_z, add_z_stb
    );

    modport slave (
        output op_a, op_b, op_valid, len, start, abort,
        input  op_ready, fifo_count, busy, done, result, eng_reset,
        input  mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack,
        output mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        input  add_a, add_b, add_a_stb, add_b_stb, add_z_ack,
        output add_a_ack, add_b_ack, add_z, add_z_stb
    );

endinterface

// File: rtl/fpu_op_fifo.sv
// rtl/fpu_op_fifo.sv - synchronous operand-pair FIFO with flush and occupancy count
module fpu_op_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a simultaneous pop frees the slot, so a full FIFO still takes the push
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_dot_sequencer.sv
// rtl/fpu_dot_sequencer.sv - sequences a shared FP32 multiplier and adder over buffered operand pairs
module fpu_dot_sequencer
    import fpu_dot_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    fpu_dot_sequencer_if.master bus
);
    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [63:0]       fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [LEN_W-1:0]  remain;
    logic [31:0]       acc;
    logic              mul_a_keep;
    logic              mul_b_keep;
    logic              add_a_keep;
    logic              add_b_keep;

    assign fifo_pop    = (state == S_FETCH) && !fifo_empty && !bus.abort;
    assign bus.op_ready = (!fifo_full || fifo_pop) && !bus.abort;
    assign bus.mul_z_ack = (state == S_MUL_WAIT) && !bus.abort;
    assign bus.add_z_ack = (state == S_ADD_WAIT) && !bus.abort;

    assign mul_a_keep = bus.mul_a_stb && !bus.mul_a_ack;
    assign mul_b_keep = bus.mul_b_stb && !bus.mul_b_ack;
    assign add_a_keep = bus.add_a_stb && !bus.add_a_ack;
    assign add_b_keep = bus.add_b_stb && !bus.add_b_ack;

    fpu_op_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.abort),
        .push  (bus.op_valid && !bus.abort),
        .din   ({bus.op_a, bus.op_b}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (bus.start) state_nxt = (bus.len == '0) ? S_FIN : S_FETCH;
            S_FETCH:     if (!fifo_empty) state_nxt = S_MUL_ISSUE;
            S_MUL_ISSUE: if (!mul_a_keep && !mul_b_keep) state_nxt = S_MUL_WAIT;
            S_MUL_WAIT:  if (bus.mul_z_stb) state_nxt = S_ADD_ISSUE;
            S_ADD_ISSUE: if (!add_a_keep && !add_b_keep) state_nxt = S_ADD_WAIT;
            S_ADD_WAIT:  if (bus.add_z_stb) state_nxt = (remain == LEN_W'(1)) ? S_FIN : S_FETCH;
            S_FIN:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remain        <= '0;
            acc           <= FP_ZERO;
            bus.result    <= FP_ZERO;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.eng_reset <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.mul_a_stb <= 1'b0;
            bus.mul_b_stb <= 1'b0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_a_stb <= 1'b0;
            bus.add_b_stb <= 1'b0;
        end else begin
            bus.eng_reset <= 1'b0;
            // each strobe retires on its own ack, independent of its partner
            bus.mul_a_stb <= mul_a_keep;
            bus.mul_b_stb <= mul_b_keep;
            bus.add_a_stb <= add_a_keep;
            bus.add_b_stb <= add_b_keep;
            if (bus.abort) begin
                bus.mul_a_stb <= 1'b0;
                bus.mul_b_stb <= 1'b0;
                bus.add_a_stb <= 1'b0;
                bus.add_b_stb <= 1'b0;
                bus.eng_reset <= 1'b1;
                bus.busy      <= 1'b0;
                bus.done      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            remain   <= bus.len;
                            acc      <= FP_ZERO;
                            bus.done <= 1'b0;
                            bus.busy <= (bus.len != '0);
                        end
                    end
                    S_FETCH: begin
                        if (!fifo_empty) begin
                            bus.mul_a     <= fifo_dout[63:32];
                            bus.mul_b     <= fifo_dout[31:0];
                            bus.mul_a_stb <= 1'b1;
                            bus.mul_b_stb <= 1'b1;
                        end
                    end
                    S_MUL_WAIT: begin
                        if (bus.mul_z_stb) begin
                            bus.add_a     <= bus.mul_z;
                            bus.add_b     <= acc;
                            bus.add_a_stb <= 1'b1;
                            bus.add_b_stb <= 1'b1;
                        end
                    end
                    S_ADD_WAIT: begin
                        if (bus.add_z_stb) begin
                            acc    <= bus.add_z;
                            remain <= remain - 1'b1;
                        end
                    end
                    S_FIN: begin
                        bus.result <= acc;
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_dot_sequencer.sv
// tb/tb_fpu_dot_sequencer.sv - randomized engine models and integer dot-product scoreboard
module tb_fpu_dot_sequencer;
    localparam int DEPTH = 8;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpu_dot_sequencer_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus();
    fpu_dot_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    int sh_a = 0, sh_b = 0;
    int mul_lat = 0, add_lat = 0;
    int mul_dly_a = 0, mul_dly_b = 0, add_dly_a = 0, add_dly_b = 0;
    logic a_alone = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic real fp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'h0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [31:0] i2fp(input int v);
        return r2fp(real'(v));
    endfunction

    // multiplier engine: per-operand ack delay, fixed product latency
    initial begin
        logic a_hs, b_hs, z_hs, a_got, b_got;
        logic [31:0] ra, rb;
        int age_a, age_b, zc;
        bus.mul_a_ack = 0; bus.mul_b_ack = 0; bus.mul_z_stb = 0; bus.mul_z = 0;
        a_got = 0; b_got = 0; age_a = 0; age_b = 0; zc = 0; ra = 0; rb = 0;
        forever begin
            @(negedge clk);
            a_hs = bus.mul_a_stb && bus.mul_a_ack;
            b_hs = bus.mul_b_stb && bus.mul_b_ack;
            z_hs = bus.mul_z_stb && bus.mul_z_ack;
            if (a_hs) ra = bus.mul_a;
            if (b_hs) rb = bus.mul_b;
            @(posedge clk); #1;
            if (reset || bus.eng_reset) begin
                bus.mul_a_ack = 0; bus.mul_b_ack = 0; bus.mul_z_stb = 0;
                a_got = 0; b_got = 0; age_a = 0; age_b = 0; zc = 0;
            end else begin
                if (a_hs) a_got = 1;
                if (b_hs) b_got = 1;
                if (z_hs) bus.mul_z_stb = 0;
                if (bus.mul_a_stb) begin bus.mul_a_ack = (age_a >= mul_dly_a); age_a++; end
                else begin bus.mul_a_ack = 0; age_a = 0; end
                if (bus.mul_b_stb) begin bus.mul_b_ack = (age_b >= mul_dly_b); age_b++; end
                else begin bus.mul_b_ack = 0; age_b = 0; end
                if (a_got && b_got && !bus.mul_z_stb) begin
                    if (zc >= mul_lat) begin
                        bus.mul_z = r2fp(fp2r(ra) * fp2r(rb));
                        bus.mul_z_stb = 1; a_got = 0; b_got = 0; zc = 0;
                    end else zc++;
                end
            end
        end
    end

    // adder engine
    initial begin
        logic a_hs, b_hs, z_hs, a_got, b_got;
        logic [31:0] ra, rb;
        int age_a, age_b, zc;
        bus.add_a_ack = 0; bus.add_b_ack = 0; bus.add_z_stb = 0; bus.add_z = 0;
        a_got = 0; b_got = 0; age_a = 0; age_b = 0; zc = 0; ra = 0; rb = 0;
        forever begin
            @(negedge clk);
            a_hs = bus.add_a_stb && bus.add_a_ack;
            b_hs = bus.add_b_stb && bus.add_b_ack;
            z_hs = bus.add_z_stb && bus.add_z_ack;
            if (a_hs) ra = bus.add_a;
            if (b_hs) rb = bus.add_b;
            @(posedge clk); #1;
            if (reset || bus.eng_reset) begin
                bus.add_a_ack = 0; bus.add_b_ack = 0; bus.add_z_stb = 0;
                a_got = 0; b_got = 0; age_a = 0; age_b = 0; zc = 0;
            end else begin
                if (a_hs) a_got = 1;
                if (b_hs) b_got = 1;
                if (z_hs) bus.add_z_stb = 0;
                if (bus.add_a_stb) begin bus.add_a_ack = (age_a >= add_dly_a); age_a++; end
                else begin bus.add_a_ack = 0; age_a = 0; end
                if (bus.add_b_stb) begin bus.add_b_ack = (age_b >= add_dly_b); age_b++; end
                else begin bus.add_b_ack = 0; age_b = 0; end
                if (a_got && b_got && !bus.add_z_stb) begin
                    if (zc >= add_lat) begin
                        bus.add_z = r2fp(fp2r(ra) + fp2r(rb));
                        bus.add_z_stb = 1; a_got = 0; b_got = 0; zc = 0;
                    end else zc++;
                end
            end
        end
    end

    // scoreboard: FIFO contents as integer pairs, running integer sum
    initial begin
        logic pa_prev, aa_prev, abort_prev, done_prev, run, push_pend;
        logic [31:0] res_prev;
        int q_a[$], q_b[$];
        int exp_len, elems, acc_i, prod_i, start_cyc, cyc, pend_a, pend_b;
        pa_prev = 0; aa_prev = 0; abort_prev = 0; done_prev = 0; run = 0; push_pend = 0;
        res_prev = 0; exp_len = 0; elems = 0; acc_i = 0; prod_i = 0; start_cyc = 0; cyc = 0;
        pend_a = 0; pend_b = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                q_a.delete(); q_b.delete();
                pa_prev = 0; aa_prev = 0; abort_prev = 0; done_prev = 0; run = 0;
                push_pend = 0; res_prev = 0;
                continue;
            end
            if (abort_prev) begin
                q_a.delete(); q_b.delete();
            end else if (push_pend) begin
                q_a.push_back(pend_a); q_b.push_back(pend_b);
            end
            if (bus.mul_a_stb && !pa_prev) begin
                if (q_a.size() == 0) check("pop_from_empty", 1, 0);
                else begin
                    check("mul_a", bus.mul_a, i2fp(q_a[0]));
                    check("mul_b", bus.mul_b, i2fp(q_b[0]));
                    prod_i = q_a[0] * q_b[0];
                    void'(q_a.pop_front()); void'(q_b.pop_front());
                    elems++;
                end
            end
            check("fifo_count", bus.fifo_count, q_a.size());
            if (bus.add_a_stb && !aa_prev) begin
                check("add_a", bus.add_a, i2fp(prod_i));
                check("add_b", bus.add_b, i2fp(acc_i));
                acc_i += prod_i;
            end
            check("eng_reset", bus.eng_reset, abort_prev);
            if (abort_prev) check("done_after_abort", bus.done, 0);
            if (bus.done && !done_prev) begin
                if (!run) check("done_unexpected", 1, 0);
                else begin
                    check("result", bus.result, i2fp(acc_i));
                    check("elements", elems, exp_len);
                    if (exp_len == 0) check("len0_latency", cyc - start_cyc, 2);
                end
                run = 0;
            end else begin
                check("result_hold", bus.result, res_prev);
            end
            check("busy", bus.busy, run && exp_len != 0);
            if (run) check("done_low", bus.done, 0);
            if (!bus.busy)
                check("idle_quiet", {bus.mul_a_stb, bus.mul_b_stb, bus.mul_z_ack,
                                     bus.add_a_stb, bus.add_b_stb, bus.add_z_ack}, 0);
            if (bus.mul_b_stb && !bus.mul_a_stb) a_alone = 1;
            push_pend = bus.op_valid && bus.op_ready;
            pend_a = sh_a; pend_b = sh_b;
            if (bus.abort) run = 0;
            else if (bus.start && !run) begin
                run = 1; exp_len = int'(bus.len); elems = 0; acc_i = 0; start_cyc = cyc;
            end
            pa_prev = bus.mul_a_stb; aa_prev = bus.add_a_stb;
            abort_prev = bus.abort; done_prev = bus.done; res_prev = bus.result;
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input int a, input int b);
        bit ok;
        ok = 0;
        sh_a = a; sh_b = b;
        bus.op_a = i2fp(a); bus.op_b = i2fp(b); bus.op_valid = 1;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1 ok = bus.op_ready;
            cyc_wait(1);
        end
        bus.op_valid = 0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic start_run(input int n);
        bus.len = LEN_W'(n); bus.start = 1;
        cyc_wait(1);
        bus.start = 0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!bus.done && i < budget) begin cyc_wait(1); i++; end
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    initial begin
        int n, exp, a, b;
        int va[$], vb[$];
        bit rdy;
        bus.op_a = 0; bus.op_b = 0; bus.op_valid = 0; bus.len = 0; bus.start = 0; bus.abort = 0;
        reset = 1;
        cyc_wait(3);
        reset = 0;
        cyc_wait(1);
        check("rst_op_ready", bus.op_ready, 1);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_busy_done", {bus.busy, bus.done, bus.eng_reset}, 0);
        check("rst_result", bus.result, 32'h0);
        check("rst_strobes", {bus.mul_a_stb, bus.mul_b_stb, bus.mul_z_ack,
                              bus.add_a_stb, bus.add_b_stb, bus.add_z_ack}, 0);

        push(1, 3); push(2, 4);
        start_run(2); wait_done(500);
        check("t1_result", bus.result, 32'h4130_0000);
        check("t1_busy", bus.busy, 0);
        check("t1_fifo_count", bus.fifo_count, 0);

        start_run(0);
        check("t2_done_early", bus.done, 0);
        cyc_wait(1);
        check("t2_done", bus.done, 1);
        check("t2_result", bus.result, 32'h0);

        push(1, 1);
        start_run(3);
        cyc_wait(10);
        check("t3_stall_busy", bus.busy, 1);
        check("t3_stall_done", bus.done, 0);
        check("t3_stall_count", bus.fifo_count, 0);
        push(1, 1); push(1, 1);
        wait_done(500);
        check("t3_result", bus.result, 32'h4040_0000);
        check("t3_no_split", a_alone, 0);

        mul_dly_b = 3;
        push(2, 3); push(1, 5);
        start_run(2); wait_done(500);
        check("t4_result", bus.result, 32'h4130_0000);
        check("t4_a_dropped_first", a_alone, 1);
        mul_dly_b = 0;

        mul_lat = 12;
        push(1, 1); push(1, 1);
        start_run(2);
        for (int i = 0; i < 100 && !bus.mul_z_ack; i++) cyc_wait(1);
        check("t5_in_mul_wait", bus.mul_z_ack, 1);
        bus.abort = 1;
        cyc_wait(1);
        bus.abort = 0;
        check("t5_eng_reset", bus.eng_reset, 1);
        check("t5_strobes", {bus.mul_a_stb, bus.mul_b_stb, bus.mul_z_ack,
                             bus.add_a_stb, bus.add_b_stb, bus.add_z_ack}, 0);
        check("t5_busy_done", {bus.busy, bus.done}, 0);
        check("t5_fifo_count", bus.fifo_count, 0);
        check("t5_result_kept", bus.result, 32'h4130_0000);
        cyc_wait(1);
        check("t5_eng_reset_pulse", bus.eng_reset, 0);
        mul_lat = 0;

        sh_a = 1; sh_b = 1;
        bus.op_a = i2fp(1); bus.op_b = i2fp(1); bus.op_valid = 1;
        for (int i = 0; i <= DEPTH; i++) begin
            #1 rdy = bus.op_ready;
            check("t6_op_ready", rdy, i < DEPTH);
            cyc_wait(1);
        end
        bus.op_valid = 0;
        check("t6_fifo_full", bus.fifo_count, DEPTH);
        start_run(DEPTH); wait_done(1000);
        check("t6_result", bus.result, 32'h4100_0000);
        check("t6_fifo_empty", bus.fifo_count, 0);

        for (int r = 0; r < 12; r++) begin
            mul_lat = $urandom_range(0, 3); add_lat = $urandom_range(0, 3);
            mul_dly_a = $urandom_range(0, 3); mul_dly_b = $urandom_range(0, 3);
            add_dly_a = $urandom_range(0, 3); add_dly_b = $urandom_range(0, 3);
            n = $urandom_range(1, DEPTH);
            exp = 0; va.delete(); vb.delete();
            for (int i = 0; i < n; i++) begin
                a = int'($urandom_range(0, 10)) - 3;
                b = int'($urandom_range(0, 10)) - 3;
                va.push_back(a); vb.push_back(b);
                exp += a * b;
            end
            if (r % 2 == 1) start_run(n);
            for (int i = 0; i < n; i++) begin
                push(va[i], vb[i]);
                if ($urandom_range(0, 1) == 1) cyc_wait($urandom_range(1, 4));
            end
            if (r % 2 == 0) start_run(n);
            wait_done(2000);
            check("rand_result", bus.result, i2fp(exp));
            check("rand_busy", bus.busy, 0);
        end

        cyc_wait(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
